// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW template fetch path: FSM encoding,
// parameter defaults and the FIFO entry layout {tmpl_id, last, data}.
package dtw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned LEN_DEF   = 20;
    localparam int unsigned NTMPL_DEF = 10;
    localparam int unsigned BASE_DEF  = 0;
    localparam int unsigned AW_DEF    = 10;
    localparam int unsigned DW_DEF    = 32;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // FIFO entry is packed as {tmpl_id, last, data}.
    function automatic int unsigned entry_w(input int unsigned tw, input int unsigned dw);
        return tw + 1 + dw;
    endfunction

endpackage

// File: rtl/dtw_fetch_fifo.sv
// Two-entry output FIFO with a registered head; the head register feeds
// the datapath directly so output fields are stable while stalled.
module dtw_fetch_fifo #(
    parameter int unsigned W = 37
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && (w_pop || (r_count != 2'd2));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_head  <= '0;
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_din;
                    else                 r_tail <= i_din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/dtw_tmpl_fetch.sv
// Template fetch sequencer: reads one template or a sweep of templates from
// the shared template memory and streams the words to the DTW datapath.
module dtw_tmpl_fetch
    import dtw_pkg::*;
#(
    parameter  int unsigned LEN   = LEN_DEF,
    parameter  int unsigned NTMPL = NTMPL_DEF,
    parameter  int unsigned BASE  = BASE_DEF,
    parameter  int unsigned AW    = AW_DEF,
    parameter  int unsigned DW    = DW_DEF,
    localparam int unsigned TW    = cnt_w(NTMPL)
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_start,
    input  logic          i_sweep,
    input  logic [TW-1:0] i_tmpl_idx,
    input  logic          i_abort,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_CS,
    output logic          o_mem_WR,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [DW-1:0] o_data,
    output logic [TW-1:0] o_tmpl_id,
    output logic          o_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int unsigned    WW      = cnt_w(LEN);
    localparam int unsigned    EW      = entry_w(TW, DW);
    localparam logic [TW-1:0]  LAST_T  = TW'(NTMPL - 1);
    localparam logic [WW-1:0]  LAST_W  = WW'(LEN - 1);
    localparam logic [TW:0]    NTMPL_V = (TW + 1)'(NTMPL);
    localparam logic [AW-1:0]  BASE_A  = AW'(BASE);
    localparam logic [AW-1:0]  LEN_A   = AW'(LEN);

    state_t        r_state;
    logic [WW-1:0] r_word;
    logic [TW-1:0] r_tmpl;
    logic          r_sweep;
    logic          r_inflight;
    logic [TW-1:0] r_inf_tmpl;
    logic          r_inf_last;
    logic [AW-1:0] r_addr;
    logic          r_err;

    logic [1:0]    w_count;
    logic [EW-1:0] w_head;
    logic          w_pop;
    logic          w_credit;
    logic          w_issue;
    logic [AW-1:0] w_addr;
    logic          w_word_last;
    logic          w_final;
    logic          w_start_ok;
    logic          w_last_xfer;
    logic          w_flush;

    assign w_pop       = o_valid && i_ready;
    // A read is issued only if the word it returns is guaranteed a FIFO slot.
    assign w_credit    = ({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_issue     = (r_state == ST_FETCH) && !i_abort && w_credit;
    assign w_addr      = BASE_A + AW'(r_tmpl) * LEN_A + AW'(r_word);
    assign w_word_last = (r_word == LAST_W);
    assign w_final     = w_word_last && (!r_sweep || (r_tmpl == LAST_T));
    assign w_start_ok  = ({1'b0, i_tmpl_idx} < NTMPL_V);
    assign w_last_xfer = w_pop && (w_count == 2'd1) && !r_inflight;
    assign w_flush     = i_abort && (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_tmpl     <= '0;
            r_sweep    <= 1'b0;
            r_inflight <= 1'b0;
            r_inf_tmpl <= '0;
            r_inf_last <= 1'b0;
            r_addr     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr     <= w_addr;
                r_inf_tmpl <= r_tmpl;
                r_inf_last <= w_word_last;
                if (w_word_last) begin
                    r_word <= '0;
                    if (!w_final) r_tmpl <= r_tmpl + TW'(1);
                end else begin
                    r_word <= r_word + WW'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        if (w_start_ok) begin
                            r_state <= ST_FETCH;
                            r_word  <= '0;
                            r_tmpl  <= i_tmpl_idx;
                            r_sweep <= i_sweep;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_abort)                   r_state <= ST_IDLE;
                    else if (w_issue && w_final)   r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (i_abort)                   r_state <= ST_IDLE;
                    else if (w_last_xfer)          r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dtw_fetch_fifo #(
        .W (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_clr   (w_flush),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_din   ({r_inf_tmpl, r_inf_last, i_mem_rdata}),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    // Completion-only cycles keep the previous address on the bus.
    assign o_mem_addr = w_issue ? w_addr : r_addr;
    assign o_mem_CS   = !(w_issue || r_inflight);
    assign o_mem_WR   = 1'b0;

    assign {o_tmpl_id, o_last, o_data} = w_head;
    assign o_valid = (w_count != 2'd0);
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);
    assign o_err   = r_err;

endmodule

// File: tb/tb_dtw_tmpl_fetch.sv
// Directed bench for dtw_tmpl_fetch: behavioural template memory, expected
// words queued at start and compared as the datapath accepts them.
module tb_dtw_tmpl_fetch;

    localparam int LEN   = 20;
    localparam int NTMPL = 10;
    localparam int BASE  = 0;

    typedef struct packed {
        logic [3:0]  t;
        logic        l;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        i_nrst;
    logic        i_start;
    logic        i_sweep;
    logic [3:0]  i_tmpl_idx;
    logic        i_abort;
    logic [9:0]  o_mem_addr;
    logic        o_mem_CS;
    logic        o_mem_WR;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_data;
    logic [3:0]  o_tmpl_id;
    logic        o_last;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    logic        rd_en;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   xfer_cnt    = 0;

    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [31:0] pd;
    logic [3:0]  pt;
    logic        pl;

    dtw_tmpl_fetch #(
        .LEN   (LEN),
        .NTMPL (NTMPL),
        .BASE  (BASE),
        .AW    (10),
        .DW    (32)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (i_nrst),
        .i_start     (i_start),
        .i_sweep     (i_sweep),
        .i_tmpl_idx  (i_tmpl_idx),
        .i_abort     (i_abort),
        .o_mem_addr  (o_mem_addr),
        .o_mem_CS    (o_mem_CS),
        .o_mem_WR    (o_mem_WR),
        .i_mem_rdata (i_mem_rdata),
        .o_data      (o_data),
        .o_tmpl_id   (o_tmpl_id),
        .o_last      (o_last),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory; bus carries garbage unless a read was issued.
    always @(posedge clk) begin
        rd_en <= !o_mem_CS;
        if (!o_mem_CS) rd_q <= mem[o_mem_addr];
    end
    assign i_mem_rdata = rd_en ? rd_q : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_words(input int t, input int n);
        for (int w = 0; w < n; w++) begin
            exp_t e;
            e.t = 4'(t);
            e.l = (w == LEN - 1);
            e.d = mem[BASE + t * LEN + w];
            sb.push_back(e);
        end
    endfunction

    function automatic void push_run(input int idx, input bit sweep);
        int last_t;
        last_t = sweep ? NTMPL - 1 : idx;
        for (int t = idx; t <= last_t; t++) push_words(t, LEN);
    endfunction

    // Leaves the caller 1 ns into cycle 1 (start accepted in cycle 0).
    task automatic start_cmd(input int idx, input bit sweep);
        @(posedge clk); #1;
        i_start    = 1'b1;
        i_sweep    = sweep;
        i_tmpl_idx = 4'(idx);
        @(posedge clk); #1;
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit rnd);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (rnd) i_ready = 1'($urandom_range(0, 1));
            if (done_cnt != d0) break;
        end
        i_ready = 1'b1;
        chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic chk_reset(input string when);
        chk({when, "_addr"},  64'(o_mem_addr), 64'd0);
        chk({when, "_cs"},    64'(o_mem_CS),   64'd1);
        chk({when, "_wr"},    64'(o_mem_WR),   64'd0);
        chk({when, "_valid"}, 64'(o_valid),    64'd0);
        chk({when, "_data"},  64'(o_data),     64'd0);
        chk({when, "_tmpl"},  64'(o_tmpl_id),  64'd0);
        chk({when, "_last"},  64'(o_last),     64'd0);
        chk({when, "_busy"},  64'(o_busy),     64'd0);
        chk({when, "_done"},  64'(o_done),     64'd0);
        chk({when, "_err"},   64'(o_err),      64'd0);
    endtask

    // Output monitor: scoreboard pops, stall stability, done counting.
    always @(negedge clk) begin
        if (!i_nrst) begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
        end else begin
            if (o_done) done_cnt++;
            chk("mem_wr_low", 64'(o_mem_WR), 64'd0);
            if (prev_stall && !prev_abort) begin
                chk("stall_valid", 64'(o_valid), 64'd1);
                chk("stall_data",  64'(o_data), 64'(pd));
                chk("stall_tag",   64'({o_tmpl_id, o_last}), 64'({pt, pl}));
            end
            if (o_valid && i_ready) begin
                xfer_cnt++;
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL extra_word: observed=%0h expected=none", o_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word_data", 64'(o_data),    64'(e.d));
                    chk("word_tmpl", 64'(o_tmpl_id), 64'(e.t));
                    chk("word_last", 64'(o_last),    64'(e.l));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_abort = i_abort;
            pd = o_data;
            pt = o_tmpl_id;
            pl = o_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        int d0;
        i_nrst = 1'b0; i_start = 1'b0; i_sweep = 1'b0; i_tmpl_idx = '0;
        i_abort = 1'b0; i_ready = 1'b1;
        for (int a = 0; a < 1024; a++) mem[a] = $urandom;
        #2;
        chk_reset("por");
        repeat (3) @(posedge clk);
        #1 i_nrst = 1'b1;

        // Single template 3, datapath always ready: exact cycle timing.
        d0 = done_cnt;
        push_run(3, 1'b0);
        start_cmd(3, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k <= 20) begin
                chk("t1_addr", 64'(o_mem_addr), 64'(60 + k - 1));
                chk("t1_cs",   64'(o_mem_CS),   64'd0);
            end
            chk("t1_valid", 64'(o_valid), 64'(k >= 3 && k <= 22));
            chk("t1_done",  64'(o_done),  64'(k == 23));
            chk("t1_busy",  64'(o_busy),  64'(k <= 23));
        end
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_sb_empty",   64'(sb.size()),    64'd0);

        // Sweep from template 8: two templates, last flags on 179 and 199.
        push_run(8, 1'b1);
        start_cmd(8, 1'b1);
        wait_done(100, 1'b0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t2_no_extra_done", 64'(o_done), 64'd0);
            chk("t2_idle",          64'(o_busy), 64'd0);
        end

        // Full sweep with a stalled start, then random back-pressure.
        push_run(0, 1'b1);
        i_ready = 1'b0;
        start_cmd(0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 2) chk("t3_addr", 64'(o_mem_addr), 64'(k - 1));
            if (k == 3) begin
                chk("t3_hold_addr", 64'(o_mem_addr), 64'd1);
                chk("t3_head",      64'(o_data),     64'(mem[BASE]));
            end
            chk("t3_cs",    64'(o_mem_CS), 64'(k >= 4));
            chk("t3_valid", 64'(o_valid),  64'(k >= 3));
        end
        wait_done(1500, 1'b1);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Out-of-range start is rejected.
        start_cmd(10, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t4_err",   64'(o_err),    64'(k == 1));
            chk("t4_busy",  64'(o_busy),   64'd0);
            chk("t4_cs",    64'(o_mem_CS), 64'd1);
            chk("t4_valid", 64'(o_valid),  64'd0);
        end

        // Abort after 7 accepted words, then restart from template 0.
        d0 = done_cnt;
        push_words(0, 7);
        tgt = xfer_cnt + 7;
        start_cmd(0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (xfer_cnt >= tgt) break;
            @(posedge clk);
        end
        chk("t5_xfers_before_abort", 64'(xfer_cnt), 64'(tgt));
        #1;
        i_abort = 1'b1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_busy",  64'(o_busy),   64'd0);
            chk("t5_valid", 64'(o_valid),  64'd0);
            chk("t5_cs",    64'(o_mem_CS), 64'd1);
        end
        chk("t5_no_done",  64'(done_cnt - d0), 64'd0);
        chk("t5_sb_empty", 64'(sb.size()),    64'd0);
        push_run(0, 1'b0);
        start_cmd(0, 1'b0);
        wait_done(60, 1'b0);
        chk("t5_restart_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a sweep, then fresh start.
        push_run(0, 1'b1);
        start_cmd(0, 1'b1);
        repeat (30) @(posedge clk);
        #3 i_nrst = 1'b0;
        #1 chk_reset("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 i_nrst = 1'b1;
        push_run(5, 1'b0);
        start_cmd(5, 1'b0);
        wait_done(60, 1'b0);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
